mem_dpi_port: RTL
=================

Name: mem_dpi_port

Overview:
- Parametrised DPI-backed simulation memory port with valid/ready request and response channels, configurable access latency and 32/64-bit data width.
- Sits between a core's LSU/IFU bus adapter and the C memory model. It replaces the fixed one-cycle memory access with a handshaked, latency-programmable slave.
- Supports one outstanding transaction, byte strobes and misalignment error reporting.

Parameters:
- DATA_W, 32, data width in bits; legal values 32 or 64.
- LATENCY, 1, cycles from request-accept edge to resp_valid; legal range 1..255.
- INIT_MEM, 1, when 1 call mem_init() once at time zero; set to 0 on all instances except one.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables for writes.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  misaligned access, or a DPI write that did not return 1.

Behaviour:
- DPI imports:
  - int mem_read_word(int addr)
  - int mem_write_word(int addr, int data, byte strb)
  - void mem_init()
- States and counter: IDLE, WAIT, RESP; 8-bit countdown cnt.
- req_ready is combinational: (state==IDLE) || (state==RESP && resp_ready). It is forced to 0 while reset=1.
- Accept occurs on a clock edge where req_valid && req_ready. On that edge:
  - All DPI calls for the transaction execute.
  - The results are latched into resp_rdata/resp_err.
  - If LATENCY==1, next state is RESP; otherwise next state is WAIT with cnt=LATENCY-2.
- WAIT:
  - cnt==0 → RESP.
  - Otherwise cnt decrements by 1.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready=1.
  - On resp_ready with no new accept → IDLE.
  - On resp_ready with a simultaneous accept → the new transaction starts; same next-state rule as from IDLE. This gives back-to-back throughput of one transaction per LATENCY cycles.
- resp_valid is high only in RESP, so it is first seen exactly LATENCY cycles after the accept edge.
- Alignment:
  - A request is misaligned if addr[log2(DATA_W/8)-1:0] != 0.
  - Misaligned → no DPI call, resp_err=1, resp_rdata=0; handshake timing is unchanged.
- Reads:
  - DATA_W=32: one call, mem_read_word(addr).
  - DATA_W=64: two calls, low word = mem_read_word(addr), high word = mem_read_word(addr+4). Address addition wraps modulo 2^32.
  - resp_err=0.
- Writes:
  - Each 32-bit lane whose 4 strobe bits are non-zero gets one mem_write_word(lane_addr, lane_data, {4'b0, lane_strb}) call.
  - Lanes with zero strobe are skipped; wstrb all-zero → no call, resp_err=0.
  - resp_err = OR over called lanes of (return != 1).
  - resp_rdata=0.
- Inputs are sampled only on the accept edge; changes at other times are ignored.
- Reset (any state, any cycle):
  - Next state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
  - A pending response is dropped without retry.
  - A write's memory side effect has already occurred at accept and is not undone.
  - No DPI call is made on a reset edge, even if req_valid=1.
- mem_init is called in an initial block only when INIT_MEM=1. It is never re-called on reset.

Decomposition:
- Shared package mem_dpi_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - WORD_W=32;
  - the function lane_count(DATA_W) returning DATA_W/32;
  - the DPI import declarations, so all memory ports share one set.
- One natural sub-module, mem_dpi_lane. It performs the per-32-bit-lane DPI read/write and returns data and error, and is instantiated DATA_W/32 times via generate.
- The FSM, counter and output registers stay in mem_dpi_port.

Test Plan:
1. LATENCY=1, DATA_W=32, resp_ready=1: write 0xDEADBEEF to 0x80000000 with wstrb=0xF, then read 0x80000000. Required: resp_valid one cycle after each accept, rdata=0xDEADBEEF, err=0.
2. LATENCY=4, DATA_W=64: read 0x80000008. Required: resp_valid first seen exactly 4 cycles after accept; rdata = {mem[0x8000000C], mem[0x80000008]}; req_ready=0 during WAIT.
3. Backpressure with LATENCY=2: hold resp_ready=0 for 5 cycles with req_valid=1. Required: resp_valid and rdata stable, req_ready=0. On resp_ready=1, the new request is accepted the same cycle and its response appears 2 cycles later.
4. Misaligned and strobe handling, DATA_W=32:
   - read 0x80000002 → err=1, rdata=0, memory untouched;
   - write wstrb=0x3, data 0x1234ABCD to a word holding 0xFFFFFFFF → readback 0xFFFFABCD;
   - wstrb=0 → err=0, memory unchanged.
5. Reset while in WAIT with LATENCY=8, for a write of 0x55 (wstrb=0x1) to 0x80000010:
   - resp_valid never rises and the block is IDLE with req_ready=1 the cycle after reset deasserts;
   - readback of 0x80000010 shows 0x55 in byte 0.
6. DPI write to an address the C model rejects (returns 0) → resp_err=1 on the response, with normal timing.

Source files
------------

// File: rtl/mem_dpi_pkg.sv
// rtl/mem_dpi_pkg.sv - shared state type, lane helpers and memory-model entry points
package mem_dpi_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int WORD_W = 32;
  localparam logic [31:0] REJECT_BASE = 32'hF000_0000;

  function automatic int lane_count(input int data_w);
    return data_w / WORD_W;
  endfunction

  // Word store shared by every port; writes at or above REJECT_BASE are refused.
  bit [31:0] mem_store [bit [31:0]];

  function automatic int mem_read_word(input int addr);
    bit [31:0] a;
    a = 32'(addr) & ~32'h3;
    if (mem_store.exists(a)) return int'(mem_store[a]);
    return 0;
  endfunction

  function automatic int mem_write_word(input int addr, input int data, input byte strb);
    bit [31:0] a;
    bit [31:0] w;
    a = 32'(addr) & ~32'h3;
    if (a >= REJECT_BASE) return 0;
    w = mem_store.exists(a) ? mem_store[a] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    mem_store[a] = w;
    return 1;
  endfunction

  function automatic void mem_init();
    mem_store.delete();
  endfunction

endpackage

// File: rtl/mem_dpi_lane.sv
// rtl/mem_dpi_lane.sv - one 32-bit lane: memory call on accept, registered data/error
module mem_dpi_lane
  import mem_dpi_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_accept,
  input  logic              i_call,
  input  logic              i_write,
  input  logic [31:0]       i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_err
);

  logic [WORD_W-1:0] r_rdata;
  logic              r_err;

  // Results are cleared on every accept so misaligned or write responses carry zero data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (i_accept) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      if (i_call) begin
        if (!i_write)
          r_rdata <= mem_read_word(int'(i_addr));
        else if (|i_wstrb)
          r_err <= (mem_write_word(int'(i_addr), int'(i_wdata), {4'b0, i_wstrb}) != 1);
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: rtl/mem_dpi_port.sv
// rtl/mem_dpi_port.sv - handshaked, latency-programmable memory-model port, one outstanding access
module mem_dpi_port
  import mem_dpi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LATENCY  = 1,
  parameter int INIT_MEM = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int         LANES    = lane_count(DATA_W);
  localparam int         ALIGN_W  = $clog2(DATA_W / 8);
  localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic                r_misalign;
  logic                w_accept;
  logic                w_aligned;
  logic [DATA_W-1:0]   w_lane_rdata;
  logic [LANES-1:0]    w_lane_err;

  assign req_ready = !reset && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && resp_ready));
  assign w_accept  = req_valid && req_ready;
  assign w_aligned = (req_addr[ALIGN_W-1:0] == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: ;
      ST_WAIT: begin
        if (r_cnt == 8'd0) w_state_nxt = ST_RESP;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // A new accept overrides the drain from RESP, giving back-to-back throughput.
    if (w_accept) begin
      if (LATENCY == 1) begin
        w_state_nxt = ST_RESP;
      end else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_misalign <= !w_aligned;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_dpi_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .i_accept (w_accept),
      .i_call   (w_aligned),
      .i_write  (req_write),
      .i_addr   (req_addr + 32'(4 * g)),
      .i_wdata  (req_wdata[g*WORD_W +: WORD_W]),
      .i_wstrb  (req_wstrb[g*4 +: 4]),
      .o_rdata  (w_lane_rdata[g*WORD_W +: WORD_W]),
      .o_err    (w_lane_err[g])
    );
  end

  if (INIT_MEM != 0) begin : g_init
    initial mem_init();
  end

  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = w_lane_rdata;
  assign resp_err   = r_misalign | (|w_lane_err);

endmodule
